// File: rtl/bus_master.sv
// -----------------------------------------------------------------------------
// bus_master
//
// Bus initiator sitting between the core's load/store/fetch logic and the
// memory controller's byte-wide bus. One request is taken at a time (byte or
// 16-bit little-endian word) and broken into one or two byte transactions.
// Each strobe is held until the responder drops bus_wait. A one-cycle
// strobe-low gap separates the two halves of a word. A recovery cycle follows
// every request and carries the single-cycle response pulse. A per-byte wait
// timer aborts accesses whose responder never answers.
//
// Parameters
//   TIMEOUT      bus_wait-high samples per byte before abort (0 = never, 0..255)
//
// Ports
//   clk          system clock, rising-edge active
//   rst          asynchronous active-high reset
//   req_valid    core request present
//   req_ready    high while idle; request accepted on req_valid && req_ready
//   req_write    1 = write, 0 = read
//   req_word     1 = 16-bit access, 0 = byte access
//   req_addr     byte address
//   req_wdata    write data, [7:0] -> addr, [15:8] -> addr+1
//   resp_valid   one-cycle completion pulse
//   resp_rdata   read data (byte reads zero-extended), held between reads
//   resp_err     1 = access aborted by wait timeout, valid with resp_valid
//   bus_address  transaction address
//   bus_data_tx  write byte
//   bus_data_rx  read byte from responder
//   bus_read     read strobe
//   bus_write    write strobe
//   bus_wait     responder busy; low = current byte access done
// -----------------------------------------------------------------------------
module bus_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_word,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        resp_valid,
  output logic [15:0] resp_rdata,
  output logic        resp_err,
  output logic [15:0] bus_address,
  output logic [7:0]  bus_data_tx,
  input  logic [7:0]  bus_data_rx,
  output logic        bus_read,
  output logic        bus_write,
  input  logic        bus_wait
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] ACC_LO  = 3'd1;
  localparam logic [2:0] GAP     = 3'd2;
  localparam logic [2:0] ACC_HI  = 3'd3;
  localparam logic [2:0] RECOVER = 3'd4;

  // The timer counts wait-high samples already seen for the current byte, so
  // the abort fires on the TIMEOUT-th consecutive high sample.
  localparam int         TIMER_LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [7:0] TIMER_LAST  = 8'(TIMER_LIMIT);
  localparam logic       TIMEOUT_ON  = (TIMEOUT != 0);

  logic [2:0]  state;
  logic        cur_write;
  logic        cur_word;
  logic [15:0] cur_addr;
  logic [7:0]  cur_hi_data;
  logic [7:0]  rdata_lo;
  logic [7:0]  timer;
  logic        timer_expired;

  assign req_ready     = (state == IDLE);
  assign timer_expired = TIMEOUT_ON && (timer == TIMER_LAST);

  // Single sequential process for the FSM and every registered output.
  // resp_valid defaults low each cycle and is raised only on the edge that
  // enters RECOVER, which makes it a one-cycle pulse by construction.
  // On a word read the low byte is parked in rdata_lo so resp_rdata keeps
  // the previous read result until the whole word is available. A timed-out
  // read leaves resp_rdata untouched; only resp_err carries meaning then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cur_write   <= 1'b0;
      cur_word    <= 1'b0;
      cur_addr    <= 16'h0000;
      cur_hi_data <= 8'h00;
      rdata_lo    <= 8'h00;
      timer       <= 8'h00;
      bus_address <= 16'h0000;
      bus_data_tx <= 8'h00;
      bus_read    <= 1'b0;
      bus_write   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_rdata  <= 16'h0000;
      resp_err    <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cur_write   <= req_write;
            cur_word    <= req_word;
            cur_addr    <= req_addr;
            cur_hi_data <= req_wdata[15:8];
            bus_address <= req_addr;
            bus_data_tx <= req_wdata[7:0];
            bus_read    <= ~req_write;
            bus_write   <= req_write;
            timer       <= 8'h00;
            resp_err    <= 1'b0;
            state       <= ACC_LO;
          end
        end

        ACC_LO: begin
          if (!bus_wait) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            if (cur_word) begin
              if (!cur_write) begin
                rdata_lo <= bus_data_rx;
              end
              state <= GAP;
            end else begin
              if (!cur_write) begin
                resp_rdata <= {8'h00, bus_data_rx};
              end
              resp_valid <= 1'b1;
              state      <= RECOVER;
            end
          end else if (timer_expired) begin
            // Abort skips the high byte of a word entirely.
            bus_read   <= 1'b0;
            bus_write  <= 1'b0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= RECOVER;
          end else begin
            timer <= timer + 8'h01;
          end
        end

        GAP: begin
          // 16-bit wrap of the address is intentional (0xFFFF -> 0x0000).
          bus_address <= cur_addr + 16'h0001;
          bus_data_tx <= cur_hi_data;
          bus_read    <= ~cur_write;
          bus_write   <= cur_write;
          timer       <= 8'h00;
          state       <= ACC_HI;
        end

        ACC_HI: begin
          if (!bus_wait) begin
            bus_read  <= 1'b0;
            bus_write <= 1'b0;
            if (!cur_write) begin
              resp_rdata <= {bus_data_rx, rdata_lo};
            end
            resp_valid <= 1'b1;
            state      <= RECOVER;
          end else if (timer_expired) begin
            bus_read   <= 1'b0;
            bus_write  <= 1'b0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= RECOVER;
          end else begin
            timer <= timer + 8'h01;
          end
        end

        RECOVER: begin
          state <= IDLE;
        end

        default: begin
          bus_read  <= 1'b0;
          bus_write <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_master.sv
// -----------------------------------------------------------------------------
// tb_bus_master
//
// Self-checking bench for bus_master. A small responder model acknowledges
// each strobe after a programmable delay (or never, when stalled) and serves
// read bytes from a fixed table. Expected responses are queued when a request
// is issued; an independent monitor pops and compares them whenever the DUT
// pulses resp_valid. Timing, strobe shape and bus-side traffic are checked
// directly by the stimulus sequence. A second instance with TIMEOUT=0 is
// driven against a responder that never answers.
// -----------------------------------------------------------------------------
module tb_bus_master;

  typedef struct packed {
    logic [15:0] rdata;
    logic        err;
    logic        chk_rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_word;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [15:0] bus_address;
  logic [7:0]  bus_data_tx;
  logic [7:0]  bus_data_rx;
  logic        bus_read;
  logic        bus_write;
  logic        bus_wait = 1'b1;

  logic        req_valid_z;
  logic        req_ready_z;
  logic [15:0] resp_rdata_z;
  logic        resp_valid_z;
  logic        resp_err_z;
  logic [15:0] bus_address_z;
  logic [7:0]  bus_data_tx_z;
  logic        bus_read_z;
  logic        bus_write_z;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic [15:0] rlog[$];
  logic [23:0] wlog[$];

  int   delay = 0;
  logic stall = 1'b0;
  int   cnt = 0;

  always #5 clk = ~clk;

  bus_master #(.TIMEOUT(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_word    (req_word),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_err    (resp_err),
    .bus_address (bus_address),
    .bus_data_tx (bus_data_tx),
    .bus_data_rx (bus_data_rx),
    .bus_read    (bus_read),
    .bus_write   (bus_write),
    .bus_wait    (bus_wait)
  );

  bus_master #(.TIMEOUT(0)) dut_z (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid_z),
    .req_ready   (req_ready_z),
    .req_write   (1'b0),
    .req_word    (1'b1),
    .req_addr    (16'h0040),
    .req_wdata   (16'h0000),
    .resp_valid  (resp_valid_z),
    .resp_rdata  (resp_rdata_z),
    .resp_err    (resp_err_z),
    .bus_address (bus_address_z),
    .bus_data_tx (bus_data_tx_z),
    .bus_data_rx (8'h00),
    .bus_read    (bus_read_z),
    .bus_write   (bus_write_z),
    .bus_wait    (1'b1)
  );

  // Read-byte table served by the responder.
  function automatic logic [7:0] rx_of(input logic [15:0] a);
    case (a)
      16'h0001: rx_of = 8'h03;
      16'h0009: rx_of = 8'h06;
      16'h000A: rx_of = 8'h00;
      16'h0020: rx_of = 8'h7C;
      16'h0021: rx_of = 8'h9D;
      default:  rx_of = 8'hEE;
    endcase
  endfunction

  assign bus_data_rx = rx_of(bus_address);

  // Registered responder: bus_wait falls 'delay' edges after the first edge
  // that sees a strobe, and rises again on the first edge that sees none.
  // Completed byte transactions are logged for bus-side checks.
  always @(posedge clk) begin
    if (bus_read && !bus_wait) rlog.push_back(bus_address);
    if (bus_write && !bus_wait) wlog.push_back({bus_address, bus_data_tx});
    if (!(bus_read || bus_write)) begin
      bus_wait <= 1'b1;
      cnt      <= 0;
    end else if (stall) begin
      bus_wait <= 1'b1;
    end else if (cnt == delay) begin
      bus_wait <= 1'b0;
    end else begin
      cnt <= cnt + 1;
    end
  end

  // Scoreboard monitor: every response pulse must match the oldest queued
  // expectation; the TIMEOUT=0 instance must never respond at all.
  always @(negedge clk) begin
    if (!rst && resp_valid) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("[TB] FAIL resp_unexpected got rdata=%h err=%b, no response expected", resp_rdata, resp_err);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (resp_err !== e.err || (e.chk_rdata && resp_rdata !== e.rdata)) begin
          bad++;
          $display("[TB] FAIL resp got rdata=%h err=%b, expected rdata=%h err=%b", resp_rdata, resp_err, e.rdata, e.err);
        end
      end
    end
    if (!rst && resp_valid_z) begin
      total++;
      bad++;
      $display("[TB] FAIL resp_z got resp_valid=1, expected 0");
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s got %h, expected %h", name, actual, expected);
    end
  endtask

  // Issues one request, optionally queues its expected response, then samples
  // once per cycle (index k = sample after edge Ek, E0 = accept edge) until
  // resp_valid or the cycle limit. Request inputs are scrambled after the
  // accept edge to show that only the accept-edge values matter.
  task automatic applyStimulus(
    input  logic        wr,
    input  logic        wd,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        push,
    input  logic [15:0] exp_rdata,
    input  logic        exp_err,
    input  logic        chk_rdata,
    input  int          limit,
    output int          resp_idx,
    output int          rd_cycles,
    output logic [31:0] trace,
    output int          unstable
  );
    logic        prev_strobe;
    logic [15:0] prev_addr;
    logic [7:0]  prev_tx;
    exp_t        e;
    rlog.delete();
    wlog.delete();
    @(negedge clk);
    req_valid = 1'b1;
    req_write = wr;
    req_word  = wd;
    req_addr  = addr;
    req_wdata = wdata;
    if (push) begin
      e.rdata     = exp_rdata;
      e.err       = exp_err;
      e.chk_rdata = chk_rdata;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = ~wr;
    req_word  = ~wd;
    req_addr  = ~addr;
    req_wdata = ~wdata;
    resp_idx    = -1;
    rd_cycles   = 0;
    trace       = 32'h0;
    unstable    = 0;
    prev_strobe = 1'b0;
    prev_addr   = 16'h0;
    prev_tx     = 8'h0;
    for (int k = 0; k < limit; k++) begin
      @(negedge clk);
      if (bus_read) rd_cycles++;
      if (bus_read || bus_write) begin
        if (k < 32) trace[k] = 1'b1;
        if (prev_strobe && (bus_address !== prev_addr || bus_data_tx !== prev_tx)) unstable++;
      end
      prev_strobe = bus_read | bus_write;
      prev_addr   = bus_address;
      prev_tx     = bus_data_tx;
      if (resp_valid) begin
        resp_idx = k;
        break;
      end
    end
  endtask

  initial begin
    int          ridx;
    int          rdc;
    int          unst;
    logic [31:0] tr;

    rst         = 1'b1;
    req_valid   = 1'b0;
    req_write   = 1'b0;
    req_word    = 1'b0;
    req_addr    = 16'h0;
    req_wdata   = 16'h0;
    req_valid_z = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset_bus_address", 32'(bus_address), 32'h0);
    checkOutput("reset_bus_data_tx", 32'(bus_data_tx), 32'h0);
    checkOutput("reset_strobes", {30'h0, bus_read, bus_write}, 32'h0);
    checkOutput("reset_resp", {15'h0, resp_valid, resp_rdata}, 32'h0);
    checkOutput("reset_resp_err", 32'(resp_err), 32'h0);
    checkOutput("reset_req_ready", 32'(req_ready), 32'h1);
    rst = 1'b0;

    $display("[TB] byte read 0x0001");
    applyStimulus(1'b0, 1'b0, 16'h0001, 16'h0000, 1'b1, 16'h0003, 1'b0, 1'b1, 20, ridx, rdc, tr, unst);
    checkOutput("byte_rd_resp_idx", 32'(ridx), 32'd2);
    checkOutput("byte_rd_read_cycles", 32'(rdc), 32'd2);
    checkOutput("byte_rd_log_size", 32'(rlog.size()), 32'd1);
    if (rlog.size() == 1) checkOutput("byte_rd_addr", 32'(rlog[0]), 32'h0001);

    $display("[TB] word read 0x0009");
    applyStimulus(1'b0, 1'b1, 16'h0009, 16'h0000, 1'b1, 16'h0006, 1'b0, 1'b1, 20, ridx, rdc, tr, unst);
    checkOutput("word_rd_resp_idx", 32'(ridx), 32'd5);
    checkOutput("word_rd_strobe_trace", tr, 32'h1B);
    checkOutput("word_rd_log_size", 32'(rlog.size()), 32'd2);
    if (rlog.size() == 2) begin
      checkOutput("word_rd_addr_lo", 32'(rlog[0]), 32'h0009);
      checkOutput("word_rd_addr_hi", 32'(rlog[1]), 32'h000A);
    end

    $display("[TB] word read 0x0020");
    applyStimulus(1'b0, 1'b1, 16'h0020, 16'h0000, 1'b1, 16'h9D7C, 1'b0, 1'b1, 20, ridx, rdc, tr, unst);
    checkOutput("word_rd2_strobe_trace", tr, 32'h1B);

    $display("[TB] word write 0xFFFF");
    applyStimulus(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 1'b1, 16'h9D7C, 1'b0, 1'b1, 20, ridx, rdc, tr, unst);
    checkOutput("word_wr_resp_idx", 32'(ridx), 32'd5);
    checkOutput("word_wr_read_cycles", 32'(rdc), 32'd0);
    checkOutput("word_wr_log_size", 32'(wlog.size()), 32'd2);
    if (wlog.size() == 2) begin
      checkOutput("word_wr_lo", 32'(wlog[0]), 32'hFFFFEF);
      checkOutput("word_wr_hi", 32'(wlog[1]), 32'h0000BE);
    end

    $display("[TB] byte write 0x0100");
    applyStimulus(1'b1, 1'b0, 16'h0100, 16'h125A, 1'b1, 16'h9D7C, 1'b0, 1'b1, 20, ridx, rdc, tr, unst);
    checkOutput("byte_wr_resp_idx", 32'(ridx), 32'd2);
    checkOutput("byte_wr_log_size", 32'(wlog.size()), 32'd1);
    if (wlog.size() == 1) checkOutput("byte_wr_data", 32'(wlog[0]), 32'h01005A);

    $display("[TB] byte read 0x0020 with 5-cycle ack delay");
    delay = 5;
    applyStimulus(1'b0, 1'b0, 16'h0020, 16'h0000, 1'b1, 16'h007C, 1'b0, 1'b1, 30, ridx, rdc, tr, unst);
    checkOutput("slow_rd_resp_idx", 32'(ridx), 32'd7);
    checkOutput("slow_rd_strobe_trace", tr, 32'h7F);
    checkOutput("slow_rd_unstable", 32'(unst), 32'd0);
    delay = 0;

    $display("[TB] word read 0x0009 against stalled responder");
    stall = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'h0009, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 40, ridx, rdc, tr, unst);
    checkOutput("timeout_resp_idx", 32'(ridx), 32'd16);
    checkOutput("timeout_strobe_trace", tr, 32'h0000FFFF);
    checkOutput("timeout_rd_log_size", 32'(rlog.size()), 32'd0);
    @(negedge clk);
    checkOutput("timeout_ready_after", 32'(req_ready), 32'h1);
    checkOutput("timeout_strobe_after", {30'h0, bus_read, bus_write}, 32'h0);
    stall = 1'b0;

    $display("[TB] reset during high-byte access");
    delay = 3;
    applyStimulus(1'b1, 1'b1, 16'h1234, 16'hA55A, 1'b0, 16'h0000, 1'b0, 1'b0, 8, ridx, rdc, tr, unst);
    checkOutput("rst_pre_resp_idx", 32'(ridx), 32'hFFFFFFFF);
    checkOutput("rst_pre_hi_access", {15'h0, bus_write, bus_address}, {15'h0, 1'b1, 16'h1235});
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_mid_strobes", {30'h0, bus_read, bus_write}, 32'h0);
    checkOutput("rst_mid_bus", {8'h0, bus_address, bus_data_tx}, 32'h0);
    checkOutput("rst_mid_resp", {14'h0, resp_valid, resp_err, resp_rdata}, 32'h0);
    checkOutput("rst_mid_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    rst   = 1'b0;
    delay = 0;
    repeat (4) @(negedge clk);
    checkOutput("rst_post_ready", 32'(req_ready), 32'h1);
    checkOutput("rst_post_resp_valid", 32'(resp_valid), 32'h0);

    $display("[TB] TIMEOUT=0 instance against stalled responder");
    @(negedge clk);
    req_valid_z = 1'b1;
    @(posedge clk);
    #1 req_valid_z = 1'b0;
    repeat (300) @(negedge clk);
    checkOutput("notimeout_still_reading", 32'(bus_read_z), 32'h1);
    checkOutput("notimeout_ready", 32'(req_ready_z), 32'h0);

    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
